avalon_mem_if_burst_split: RTL and testbench
============================================

AVALON_MEM_IF_BURST_SPLIT -- requirements
Module: avalon_mem_if_burst_split

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: word address width.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 4: burstcount width on both sides.
REQ-004 SHALL have parameter MAX_BURST, default 4: largest m0 burst; power of two, 1..2^(BURST_CNT_WIDTH-1).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 SHALL provide the following ports:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- s0_read, s0_write  in  1 each  AFU-side request strobes.
- s0_address  in  ADDR_WIDTH  word address.
- s0_burstcount  in  BURST_CNT_WIDTH  beats, 1..2^BURST_CNT_WIDTH-1.
- s0_writedata  in  DATA_WIDTH  write data.
- s0_byteenable  in  DATA_WIDTH/8  byte enables.
- s0_waitrequest  out  1  stall to AFU.
- s0_readdata  out  DATA_WIDTH  read data to AFU.
- s0_readdatavalid  out  1  read data valid.
- m0_* mirrors s0_* toward the FIU-side register pipeline, with directions reversed.

Function
REQ-007 SHALL keep state IDLE, RD_SPLIT or WR_BURST.
REQ-008 IDLE, s0_read with burstcount <= MAX_BURST: pass s0 to m0 combinationally, 0 latency; s0_waitrequest = m0_waitrequest.
REQ-009 IDLE, s0_read with burstcount N > MAX_BURST:
- Drive m0 with s0_address and burstcount MAX_BURST; hold s0_waitrequest=1.
- On m0 accept, latch next address = address+MAX_BURST and remaining = N-MAX_BURST; go to RD_SPLIT.
REQ-010 RD_SPLIT:
- m0_read=1, registered address, burstcount=min(remaining,MAX_BURST).
- On accept: address += MAX_BURST; remaining -= issued.
- s0_waitrequest=0 only in the cycle the final sub-request is accepted; then go to IDLE.
REQ-011 Write burst N, first beat accepted:
- m0_burstcount = min(N,MAX_BURST), m0_address = s0_address.
- Latch base address and beats_left=N-1; go to WR_BURST if N>1.
REQ-012 WR_BURST:
- Data and byteenable pass through combinationally; s0_waitrequest = m0_waitrequest.
- Each beat starting a new sub-burst carries burstcount=min(beats_left,MAX_BURST) and address=base+beats_done.
- After the last beat is accepted, go to IDLE.
REQ-013 m0_burstcount and m0_address SHALL stay stable while m0_waitrequest=1.
REQ-014 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-015 m0_readdata and m0_readdatavalid SHALL pass to s0 unchanged in the same cycle; order is preserved.
REQ-016 The following are illegal and SHALL be flagged by a simulation assertion:
- s0_read and s0_write asserted together.
- burstcount 0.
- s0_read asserted during WR_BURST.

Reset
REQ-017 reset_n=0 SHALL immediately force:
- state IDLE; all counters and latched addresses 0.
- m0_read=0, m0_write=0, s0_waitrequest=1.
REQ-018 Reset mid-burst SHALL abandon the split; the first request after reset_n rises starts fresh.

Configuration
REQ-019 With AVALON_MEM_IF_BURST_SPLIT_STATS_EN defined:
- Add output split_count (32 bits), reset 0.
- It increments once per s0 request that was split into more than one m0 burst, and saturates at all-ones.
REQ-020 Without the macro, the port and counter SHALL be absent.

Structure
REQ-021 State enum and a min(a,b) burst-size function SHALL live in package avalon_mem_if_burst_split_pkg.
REQ-022 Read sub-request generation SHALL be sub-module avalon_mem_if_burst_split_rd_gen. Write tracking stays in the top module.

Verification
REQ-023 The bench SHALL cover these scenarios (MAX_BURST=4, ADDR_WIDTH=10):
- Read addr 0x010, burst 10, m0_waitrequest=0 -> m0 reads (0x010,4),(0x014,4),(0x018,2) on 3 consecutive cycles; s0_waitrequest low only on the third.
- Write addr 0x020, burst 6, data D0..D5 -> beat D0 carries (0x020,4), beat D4 carries (0x024,2); data order D0..D5.
- Read addr 0x030, burst 3 -> single m0 read (0x030,3) in the same cycle; readdatavalid beats pass through with 0 latency.
- m0_waitrequest=1 for 2 cycles on the second sub-read -> m0 holds (0x014,4) stable; s0_waitrequest stays 1.
- Read addr 0x3FE, burst 8 -> m0 reads (0x3FE,4),(0x002,4).
- reset_n=0 during RD_SPLIT -> m0_read=0 and s0_waitrequest=1 immediately; after release, read burst 2 issues as (addr,2).

Source files
------------

// File: rtl/avalon_mem_if_burst_split_pkg.sv
// avalon_mem_if_burst_split_pkg: FSM state type and burst-size helper for the burst splitter
package avalon_mem_if_burst_split_pkg;
  typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;
  function automatic logic [31:0] burst_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/avalon_mem_if_burst_split_rd_gen.sv
// avalon_mem_if_burst_split_rd_gen: next address and remaining beats for split read sub-requests
module avalon_mem_if_burst_split_rd_gen
  import avalon_mem_if_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       step,
  input  logic [ADDR_WIDTH-1:0]      s0_address,
  input  logic [BURST_CNT_WIDTH-1:0] s0_burstcount,
  output logic [ADDR_WIDTH-1:0]      rd_address,
  output logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  output logic                       rd_last
);
  localparam logic [ADDR_WIDTH-1:0] max_a = ADDR_WIDTH'(MAX_BURST);
  localparam logic [BURST_CNT_WIDTH-1:0] max_b = BURST_CNT_WIDTH'(MAX_BURST);
  logic [BURST_CNT_WIDTH-1:0] remaining;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_address <= '0;
      remaining <= '0;
    end else if (start) begin
      rd_address <= s0_address + max_a;
      remaining <= s0_burstcount - max_b;
    end else if (step) begin
      rd_address <= rd_address + max_a;
      remaining <= remaining - rd_burstcount;
    end
  end
  assign rd_burstcount = BURST_CNT_WIDTH'(burst_min(32'(remaining), MAX_BURST));
  assign rd_last = remaining <= max_b;
endmodule

// File: rtl/avalon_mem_if_burst_split.sv
// avalon_mem_if_burst_split: splits s0 bursts into m0 bursts of at most MAX_BURST; AVALON_MEM_IF_BURST_SPLIT_STATS_EN adds split_count
module avalon_mem_if_burst_split
  import avalon_mem_if_burst_split_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s0_read,
  input  logic                       s0_write,
  input  logic [ADDR_WIDTH-1:0]      s0_address,
  input  logic [BURST_CNT_WIDTH-1:0] s0_burstcount,
  input  logic [DATA_WIDTH-1:0]      s0_writedata,
  input  logic [DATA_WIDTH/8-1:0]    s0_byteenable,
  output logic                       s0_waitrequest,
  output logic [DATA_WIDTH-1:0]      s0_readdata,
  output logic                       s0_readdatavalid,
  output logic                       m0_read,
  output logic                       m0_write,
  output logic [ADDR_WIDTH-1:0]      m0_address,
  output logic [BURST_CNT_WIDTH-1:0] m0_burstcount,
  output logic [DATA_WIDTH-1:0]      m0_writedata,
  output logic [DATA_WIDTH/8-1:0]    m0_byteenable,
  input  logic                       m0_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m0_readdata,
  input  logic                       m0_readdatavalid
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
  , output logic [31:0]              split_count
`endif
);
  localparam logic [BURST_CNT_WIDTH-1:0] max_b = BURST_CNT_WIDTH'(MAX_BURST);
  localparam logic [BURST_CNT_WIDTH-1:0] one_b = BURST_CNT_WIDTH'(1);
  state_t state, state_nx;
  logic big_rd, rd_start, rd_step, wr_start, wr_step, rd_last;
  logic [ADDR_WIDTH-1:0] rd_address, wr_base;
  logic [BURST_CNT_WIDTH-1:0] rd_burstcount, wr_done, wr_left;
  assign big_rd = s0_read && s0_burstcount > max_b;
  assign s0_readdata = m0_readdata;
  assign s0_readdatavalid = m0_readdatavalid;
  assign m0_writedata = s0_writedata;
  assign m0_byteenable = s0_byteenable;
  avalon_mem_if_burst_split_rd_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BURST_CNT_WIDTH(BURST_CNT_WIDTH),
    .MAX_BURST(MAX_BURST)
  ) u_rd_gen (
    .clk(clk),
    .reset_n(reset_n),
    .start(rd_start),
    .step(rd_step),
    .s0_address(s0_address),
    .s0_burstcount(s0_burstcount),
    .rd_address(rd_address),
    .rd_burstcount(rd_burstcount),
    .rd_last(rd_last)
  );
  always_comb begin
    state_nx = state;
    m0_read = 1'b0;
    m0_write = 1'b0;
    m0_address = s0_address;
    m0_burstcount = BURST_CNT_WIDTH'(burst_min(32'(s0_burstcount), MAX_BURST));
    s0_waitrequest = m0_waitrequest;
    rd_start = 1'b0;
    rd_step = 1'b0;
    wr_start = 1'b0;
    wr_step = 1'b0;
    case (state)
      RD_SPLIT: begin
        m0_read = 1'b1;
        m0_address = rd_address;
        m0_burstcount = rd_burstcount;
        s0_waitrequest = m0_waitrequest || !rd_last;
        rd_step = !m0_waitrequest;
        state_nx = (rd_step && rd_last) ? IDLE : RD_SPLIT;
      end
      WR_BURST: begin
        m0_write = s0_write;
        m0_address = wr_base + ADDR_WIDTH'(wr_done);
        m0_burstcount = BURST_CNT_WIDTH'(burst_min(32'(wr_left), MAX_BURST));
        wr_step = s0_write && !m0_waitrequest;
        state_nx = (wr_step && wr_left == one_b) ? IDLE : WR_BURST;
      end
      default: begin
        m0_read = s0_read;
        m0_write = s0_write;
        s0_waitrequest = big_rd || m0_waitrequest;
        rd_start = big_rd && !m0_waitrequest;
        wr_start = s0_write && !m0_waitrequest && s0_burstcount > one_b;
        state_nx = rd_start ? RD_SPLIT : wr_start ? WR_BURST : IDLE;
      end
    endcase
    if (!reset_n) begin
      m0_read = 1'b0;
      m0_write = 1'b0;
      s0_waitrequest = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wr_base <= '0;
      wr_done <= '0;
      wr_left <= '0;
    end else begin
      state <= state_nx;
      if (wr_start) begin
        wr_base <= s0_address;
        wr_done <= one_b;
        wr_left <= s0_burstcount - one_b;
      end else if (wr_step) begin
        wr_done <= wr_done + one_b;
        wr_left <= wr_left - one_b;
      end
    end
  end
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) split_count <= '0;
    else if ((rd_start || (wr_start && s0_burstcount > max_b)) && split_count != '1) split_count <= split_count + 32'd1;
  end
`endif
  assert property (@(posedge clk) disable iff (!reset_n) !(s0_read && s0_write));
  assert property (@(posedge clk) disable iff (!reset_n) (state == IDLE && (s0_read || s0_write)) |-> s0_burstcount != '0);
  assert property (@(posedge clk) disable iff (!reset_n) state == WR_BURST |-> !s0_read);
endmodule

// File: tb/tb_avalon_mem_if_burst_split.sv
// tb_avalon_mem_if_burst_split: directed bench with a queue model of expected m0 sub-requests
module tb_avalon_mem_if_burst_split;
  localparam int DW = 32, AW = 10, BW = 4, MB = 4;
  typedef struct {
    logic wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic chk;
    logic [DW-1:0] data;
    logic [DW/8-1:0] be;
    logic s0wr;
  } exp_t;
  logic clk = 0, reset_n = 0;
  logic s0_read = 0, s0_write = 0;
  logic [AW-1:0] s0_address = '0;
  logic [BW-1:0] s0_burstcount = 1;
  logic [DW-1:0] s0_writedata = '0;
  logic [DW/8-1:0] s0_byteenable = '1;
  logic s0_waitrequest, s0_readdatavalid;
  logic [DW-1:0] s0_readdata;
  logic m0_read, m0_write;
  logic [AW-1:0] m0_address;
  logic [BW-1:0] m0_burstcount;
  logic [DW-1:0] m0_writedata;
  logic [DW/8-1:0] m0_byteenable;
  logic m0_waitrequest = 0, m0_readdatavalid = 0;
  logic [DW-1:0] m0_readdata = '0;
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
  logic [31:0] split_count;
`endif
  int n_cmp = 0, n_fail = 0, cyc = 0, w;
  exp_t expq[$];
  exp_t e;
  logic [AW-1:0] log_a[$];
  logic [BW-1:0] log_b[$];
  logic [DW-1:0] log_d[$];
  int log_c[$];
  avalon_mem_if_burst_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address), .s0_burstcount(s0_burstcount),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_burstcount(m0_burstcount),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid)
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
    , .split_count(split_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [DW/8-1:0] be_of(input int i);
    return (DW/8)'(1 << (i % 4));
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int i);
    return 32'hD000_0000 + DW'(i);
  endfunction
  task automatic model_read(input logic [AW-1:0] a, input int n);
    exp_t x;
    for (int off = 0; off < n; off += MB) begin
      x.wr = 0;
      x.addr = AW'(32'(a) + off);
      x.bc = BW'((n - off < MB) ? n - off : MB);
      x.chk = 1;
      x.data = '0;
      x.be = '0;
      x.s0wr = (off + MB >= n) ? 1'b0 : 1'b1;
      expq.push_back(x);
    end
  endtask
  task automatic model_write(input logic [AW-1:0] a, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.wr = 1;
      x.addr = AW'(32'(a) + i);
      x.bc = BW'((n - i < MB) ? n - i : MB);
      x.chk = (i % MB == 0);
      x.data = wdata_of(i);
      x.be = be_of(i);
      x.s0wr = 0;
      expq.push_back(x);
    end
  endtask
  task automatic clear_log();
    log_a.delete();
    log_b.delete();
    log_d.delete();
    log_c.delete();
  endtask
  task automatic do_read(input logic [AW-1:0] a, input int n, output int waits);
    model_read(a, n);
    @(posedge clk);
    #1;
    s0_read = 1;
    s0_address = a;
    s0_burstcount = BW'(n);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (s0_waitrequest && waits < 64);
    check("rd_accept", s0_waitrequest, 0);
    @(posedge clk);
    #1;
    s0_read = 0;
  endtask
  task automatic do_write(input logic [AW-1:0] a, input int n);
    int k;
    model_write(a, n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s0_write = 1;
      s0_address = a;
      s0_burstcount = BW'(n);
      s0_writedata = wdata_of(i);
      s0_byteenable = be_of(i);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (s0_waitrequest && k < 64);
      check("wr_accept", s0_waitrequest, 0);
    end
    @(posedge clk);
    #1;
    s0_write = 0;
  endtask
  always @(negedge clk) if (reset_n) begin
    check("rvalid_pass", s0_readdatavalid, m0_readdatavalid);
    if (m0_readdatavalid) check("rdata_pass", s0_readdata, m0_readdata);
    if ((m0_read || m0_write) && !m0_waitrequest) begin
      log_a.push_back(m0_address);
      log_b.push_back(m0_burstcount);
      log_d.push_back(m0_writedata);
      log_c.push_back(cyc);
      if (expq.size() == 0) check("unexpected_m0_req", 1, 0);
      else begin
        e = expq.pop_front();
        check("m0_write", m0_write, e.wr);
        check("m0_read", m0_read, !e.wr);
        if (e.chk) begin
          check("m0_address", m0_address, e.addr);
          check("m0_burstcount", m0_burstcount, e.bc);
        end
        if (e.wr) begin
          check("m0_writedata", m0_writedata, e.data);
          check("m0_byteenable", m0_byteenable, e.be);
        end
        check("s0_waitrequest_at_accept", s0_waitrequest, e.s0wr);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    s0_read = 1;
    s0_address = 10'h055;
    #12;
    check("rst_m0_read", m0_read, 0);
    check("rst_m0_write", m0_write, 0);
    check("rst_s0_waitrequest", s0_waitrequest, 1);
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
    check("rst_split_count", split_count, 0);
`endif
    s0_read = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    clear_log();
    do_read(10'h010, 10, w);
    check("s1_waits", w, 3);
    check("s1_n", log_a.size(), 3);
    check("s1_a0", log_a[0], 10'h010);
    check("s1_b0", log_b[0], 4);
    check("s1_a1", log_a[1], 10'h014);
    check("s1_b1", log_b[1], 4);
    check("s1_a2", log_a[2], 10'h018);
    check("s1_b2", log_b[2], 2);
    check("s1_consecutive", log_c[2] - log_c[0], 2);
    clear_log();
    do_write(10'h020, 6);
    check("s2_n", log_a.size(), 6);
    check("s2_a0", log_a[0], 10'h020);
    check("s2_b0", log_b[0], 4);
    check("s2_d0", log_d[0], 32'hD000_0000);
    check("s2_a4", log_a[4], 10'h024);
    check("s2_b4", log_b[4], 2);
    check("s2_d4", log_d[4], 32'hD000_0004);
    check("s2_d5", log_d[5], 32'hD000_0005);
    clear_log();
    do_read(10'h030, 3, w);
    check("s3_waits", w, 1);
    check("s3_a0", log_a[0], 10'h030);
    check("s3_b0", log_b[0], 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      m0_readdatavalid = 1;
      m0_readdata = 32'hCAFE_0000 + DW'(i);
      @(negedge clk);
      check("s3_rvalid", s0_readdatavalid, 1);
      check("s3_rdata", s0_readdata, 32'hCAFE_0000 + 64'(i));
    end
    @(posedge clk);
    #1;
    m0_readdatavalid = 0;
    clear_log();
    model_read(10'h010, 10);
    @(posedge clk);
    #1;
    s0_read = 1;
    s0_address = 10'h010;
    s0_burstcount = 10;
    @(negedge clk);
    @(posedge clk);
    #1;
    m0_waitrequest = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s4_hold_read", m0_read, 1);
      check("s4_hold_addr", m0_address, 10'h014);
      check("s4_hold_bc", m0_burstcount, 4);
      check("s4_hold_s0wr", s0_waitrequest, 1);
      @(posedge clk);
      #1;
    end
    m0_waitrequest = 0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (s0_waitrequest && w < 64);
    check("s4_waits", w, 2);
    @(posedge clk);
    #1;
    s0_read = 0;
    check("s4_n", log_a.size(), 3);
    check("s4_a1", log_a[1], 10'h014);
    clear_log();
    do_read(10'h3FE, 8, w);
    check("s5_waits", w, 2);
    check("s5_a0", log_a[0], 10'h3FE);
    check("s5_b0", log_b[0], 4);
    check("s5_a1", log_a[1], 10'h002);
    check("s5_b1", log_b[1], 4);
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
    check("split_count", split_count, 4);
`endif
    model_read(10'h100, 10);
    @(posedge clk);
    #1;
    s0_read = 1;
    s0_address = 10'h100;
    s0_burstcount = 10;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    check("s6_rst_m0_read", m0_read, 0);
    check("s6_rst_s0wr", s0_waitrequest, 1);
    s0_read = 0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    @(negedge clk);
    check("s6_idle_m0_read", m0_read, 0);
    clear_log();
    do_read(10'h200, 2, w);
    check("s6_waits", w, 1);
    check("s6_n", log_a.size(), 1);
    check("s6_a0", log_a[0], 10'h200);
    check("s6_b0", log_b[0], 2);
`ifdef AVALON_MEM_IF_BURST_SPLIT_STATS_EN
    check("s6_split_count", split_count, 0);
`endif
    repeat (2) @(posedge clk);
    check("model_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
